edit_mode: RTL and testbench

- Edit-mode input engine between the keystroke pacer (7-bit ASCII plus one-cycle ready strobe) and the memory controller's character-write and highlight-write ports.
- Maintains a text cursor and services keystrokes:
  - printable: write the character, advance the cursor
  - backspace: retreat and erase
  - enter: newline
- Every cursor move is mirrored in highlight memory: clear the old cell, set the new one.
- Grid size follows the sL (large mode) switch.

---
 rtl/edit_mode.sv | 237 +++++++++++++++++++++++
 tb/tb_edit_mode.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edit_mode.sv
// Edit-mode keystroke engine: turns paced ASCII strobes into character writes
// and keeps the highlight memory tracking the text cursor.
module edit_mode #(
    parameter int unsigned COLS_L = 80,
    parameter int unsigned ROWS_L = 60,
    parameter int unsigned COLS_S = 40,
    parameter int unsigned ROWS_S = 30
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sL,
    input  logic       ready,
    input  logic [6:0] asciiin,
    input  logic [5:0] colour,
    output logic [6:0] cx,
    output logic [5:0] cy,
    output logic [6:0] cascii,
    output logic [5:0] ccol,
    output logic       cwren,
    output logic [6:0] hx,
    output logic [5:0] hy,
    output logic       hl,
    output logic       hen,
    output logic [6:0] curx,
    output logic [5:0] cury,
    output logic       busy
);

    localparam int unsigned XW = 7;
    localparam int unsigned YW = 6;
    localparam logic [6:0] ASCII_BS    = 7'h08;
    localparam logic [6:0] ASCII_CR    = 7'h0D;
    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [6:0] ASCII_TILDE = 7'h7E;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_HL_CLR,
        S_HL_SET
    } state_t;

    state_t state, state_d;

    logic          sl_q, sl_d;
    logic [XW-1:0] nxt_x, nxt_x_d, old_x, old_x_d;
    logic [YW-1:0] nxt_y, nxt_y_d, old_y, old_y_d;
    logic [XW-1:0] cx_d, hx_d, curx_d;
    logic [YW-1:0] cy_d, hy_d, cury_d;
    logic [6:0]    cascii_d;
    logic [5:0]    ccol_d;
    logic          cwren_d, hen_d, hl_d, busy_d;

    logic          is_print, is_bs, is_cr, sl_chg;
    logic [XW-1:0] cols_m1, adv_x, ret_x;
    logic [YW-1:0] rows_m1, adv_y, ret_y, ent_y;

    // Keystroke classification and grid bounds for the current mode
    assign is_print = (asciiin >= ASCII_SPACE) && (asciiin <= ASCII_TILDE);
    assign is_bs    = (asciiin == ASCII_BS);
    assign is_cr    = (asciiin == ASCII_CR);
    assign sl_chg   = (sL != sl_q);
    assign cols_m1  = sL ? XW'(COLS_L - 1) : XW'(COLS_S - 1);
    assign rows_m1  = sL ? YW'(ROWS_L - 1) : YW'(ROWS_S - 1);

    // Cursor neighbours: advance, retreat and newline targets
    always_comb begin
        adv_x = curx + XW'(1);
        adv_y = cury;
        if (curx >= cols_m1) begin
            adv_x = '0;
            adv_y = (cury >= rows_m1) ? '0 : cury + YW'(1);
        end
        ret_x = curx - XW'(1);
        ret_y = cury;
        if (curx == '0) begin
            if (cury == '0) begin
                ret_x = '0;
                ret_y = '0;
            end else begin
                ret_x = cols_m1;
                ret_y = cury - YW'(1);
            end
        end
        ent_y = (cury >= rows_m1) ? '0 : cury + YW'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_INIT;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_INIT:   state_d = S_IDLE;
            S_IDLE: begin
                if (sl_chg)                        state_d = S_HL_CLR;
                else if (ready && (is_print || is_bs)) state_d = S_WRITE;
                else if (ready && is_cr)           state_d = S_HL_CLR;
            end
            S_WRITE:  state_d = S_HL_CLR;
            S_HL_CLR: state_d = S_HL_SET;
            S_HL_SET: state_d = S_IDLE;
            default:  state_d = S_INIT;
        endcase
    end

    // Outputs are registered, so each state's strobes are computed on entry
    always_comb begin
        sl_d     = sl_q;
        nxt_x_d  = nxt_x;
        nxt_y_d  = nxt_y;
        old_x_d  = old_x;
        old_y_d  = old_y;
        cx_d     = cx;
        cy_d     = cy;
        cascii_d = cascii;
        ccol_d   = ccol;
        hx_d     = hx;
        hy_d     = hy;
        hl_d     = hl;
        curx_d   = curx;
        cury_d   = cury;
        cwren_d  = 1'b0;
        hen_d    = 1'b0;
        busy_d   = (state_d != S_IDLE);
        case (state)
            S_INIT: begin
                sl_d  = sL;
                hen_d = 1'b1;
                hl_d  = 1'b1;
                hx_d  = '0;
                hy_d  = '0;
            end
            S_IDLE: begin
                sl_d = sL;
                if (sl_chg) begin
                    old_x_d = curx;
                    old_y_d = cury;
                    curx_d  = '0;
                    cury_d  = '0;
                    hen_d   = 1'b1;
                    hl_d    = 1'b0;
                    hx_d    = curx;
                    hy_d    = cury;
                end else if (ready && (is_print || is_bs)) begin
                    old_x_d  = curx;
                    old_y_d  = cury;
                    cwren_d  = 1'b1;
                    ccol_d   = colour;
                    if (is_print) begin
                        cx_d     = curx;
                        cy_d     = cury;
                        cascii_d = asciiin;
                        nxt_x_d  = adv_x;
                        nxt_y_d  = adv_y;
                    end else begin
                        cx_d     = ret_x;
                        cy_d     = ret_y;
                        cascii_d = ASCII_SPACE;
                        nxt_x_d  = ret_x;
                        nxt_y_d  = ret_y;
                    end
                end else if (ready && is_cr) begin
                    old_x_d = curx;
                    old_y_d = cury;
                    nxt_x_d = '0;
                    nxt_y_d = ent_y;
                    curx_d  = '0;
                    cury_d  = ent_y;
                    hen_d   = 1'b1;
                    hl_d    = 1'b0;
                    hx_d    = curx;
                    hy_d    = cury;
                end
            end
            S_WRITE: begin
                curx_d = nxt_x;
                cury_d = nxt_y;
                hen_d  = 1'b1;
                hl_d   = 1'b0;
                hx_d   = old_x;
                hy_d   = old_y;
            end
            S_HL_CLR: begin
                hen_d = 1'b1;
                hl_d  = 1'b1;
                hx_d  = curx;
                hy_d  = cury;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sl_q   <= 1'b0;
            nxt_x  <= '0;
            nxt_y  <= '0;
            old_x  <= '0;
            old_y  <= '0;
            cx     <= '0;
            cy     <= '0;
            cascii <= '0;
            ccol   <= '0;
            cwren  <= 1'b0;
            hx     <= '0;
            hy     <= '0;
            hl     <= 1'b0;
            hen    <= 1'b0;
            curx   <= '0;
            cury   <= '0;
            busy   <= 1'b1;
        end else begin
            sl_q   <= sl_d;
            nxt_x  <= nxt_x_d;
            nxt_y  <= nxt_y_d;
            old_x  <= old_x_d;
            old_y  <= old_y_d;
            cx     <= cx_d;
            cy     <= cy_d;
            cascii <= cascii_d;
            ccol   <= ccol_d;
            cwren  <= cwren_d;
            hx     <= hx_d;
            hy     <= hy_d;
            hl     <= hl_d;
            hen    <= hen_d;
            curx   <= curx_d;
            cury   <= cury_d;
            busy   <= busy_d;
        end
    end

endmodule

// File: tb/tb_edit_mode.sv
// Directed bench for edit_mode: keystroke writes, cursor wrap/retreat,
// newline, ignored codes, dropped strobes, mode switch and async reset.
module tb_edit_mode;

    logic       clk;
    logic       resetn;
    logic       sL;
    logic       ready;
    logic [6:0] asciiin;
    logic [5:0] colour;
    logic [6:0] cx;
    logic [5:0] cy;
    logic [6:0] cascii;
    logic [5:0] ccol;
    logic       cwren;
    logic [6:0] hx;
    logic [5:0] hy;
    logic       hl;
    logic       hen;
    logic [6:0] curx;
    logic [5:0] cury;
    logic       busy;

    int checks = 0;
    int errors = 0;

    edit_mode dut (
        .clk     (clk),
        .resetn  (resetn),
        .sL      (sL),
        .ready   (ready),
        .asciiin (asciiin),
        .colour  (colour),
        .cx      (cx),
        .cy      (cy),
        .cascii  (cascii),
        .ccol    (ccol),
        .cwren   (cwren),
        .hx      (hx),
        .hy      (hy),
        .hl      (hl),
        .hen     (hen),
        .curx    (curx),
        .cury    (cury),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; returns sampled in the cycle after the strobe
    task automatic key(input logic [6:0] c);
        asciiin = c;
        ready   = 1'b1;
        tick();
        ready   = 1'b0;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 10 && busy; i++) tick();
        check("idle", 32'(busy), 32'd0);
    endtask

    task automatic type_n(input int n);
        for (int i = 0; i < n; i++) begin
            key(7'h2E);
            wait_idle();
        end
    endtask

    task automatic enter_n(input int n);
        for (int i = 0; i < n; i++) begin
            key(7'h0D);
            wait_idle();
        end
    endtask

    initial begin
        resetn  = 1'b0;
        sL      = 1'b1;
        ready   = 1'b0;
        asciiin = 7'h00;
        colour  = 6'h00;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_hen", 32'(hen), 32'd0);
        check("rst_cwren", 32'(cwren), 32'd0);
        check("rst_curx", 32'(curx), 32'd0);
        check("rst_cury", 32'(cury), 32'd0);

        // Startup highlight at (0,0)
        resetn = 1'b1;
        tick();
        check("init_hen", 32'(hen), 32'd1);
        check("init_hl", 32'(hl), 32'd1);
        check("init_hx", 32'(hx), 32'd0);
        check("init_hy", 32'(hy), 32'd0);
        check("init_busy", 32'(busy), 32'd0);
        tick();
        check("init_hen_off", 32'(hen), 32'd0);

        // 'A' at (0,0) with a second strobe landing while busy
        colour = 6'h2A;
        key(7'h41);
        check("a_cwren", 32'(cwren), 32'd1);
        check("a_cx", 32'(cx), 32'd0);
        check("a_cy", 32'(cy), 32'd0);
        check("a_cascii", 32'(cascii), 32'h41);
        check("a_ccol", 32'(ccol), 32'h2A);
        check("a_busy", 32'(busy), 32'd1);
        asciiin = 7'h42;
        ready   = 1'b1;
        tick();
        ready   = 1'b0;
        check("a_clr_hen", 32'(hen), 32'd1);
        check("a_clr_hl", 32'(hl), 32'd0);
        check("a_clr_hx", 32'(hx), 32'd0);
        check("a_clr_cwren", 32'(cwren), 32'd0);
        tick();
        check("a_set_hen", 32'(hen), 32'd1);
        check("a_set_hl", 32'(hl), 32'd1);
        check("a_set_hx", 32'(hx), 32'd1);
        check("a_set_hy", 32'(hy), 32'd0);
        check("a_curx", 32'(curx), 32'd1);
        tick();
        check("a_idle", 32'(busy), 32'd0);
        tick();
        check("drop_curx", 32'(curx), 32'd1);
        check("drop_cascii", 32'(cascii), 32'h41);

        // Backspace from (1,0), then again at (0,0)
        key(7'h08);
        check("bs1_cwren", 32'(cwren), 32'd1);
        check("bs1_cx", 32'(cx), 32'd0);
        check("bs1_cascii", 32'(cascii), 32'h20);
        wait_idle();
        check("bs1_curx", 32'(curx), 32'd0);
        key(7'h08);
        check("bs0_cwren", 32'(cwren), 32'd1);
        check("bs0_cx", 32'(cx), 32'd0);
        check("bs0_cy", 32'(cy), 32'd0);
        check("bs0_cascii", 32'(cascii), 32'h20);
        wait_idle();
        check("bs0_curx", 32'(curx), 32'd0);
        check("bs0_cury", 32'(cury), 32'd0);

        // Backspace at (0,3) retreats to end of row 2
        enter_n(3);
        check("cr3_cury", 32'(cury), 32'd3);
        key(7'h08);
        check("bsrow_cx", 32'(cx), 32'd79);
        check("bsrow_cy", 32'(cy), 32'd2);
        wait_idle();
        check("bsrow_curx", 32'(curx), 32'd79);
        check("bsrow_cury", 32'(cury), 32'd2);

        // ESC is ignored
        key(7'h1B);
        check("esc_cwren", 32'(cwren), 32'd0);
        check("esc_hen", 32'(hen), 32'd0);
        check("esc_busy", 32'(busy), 32'd0);

        // Enter on the last row wraps to row 0
        enter_n(57);
        type_n(12);
        check("pre_cr_curx", 32'(curx), 32'd12);
        check("pre_cr_cury", 32'(cury), 32'd59);
        key(7'h0D);
        check("cr_cwren", 32'(cwren), 32'd0);
        check("cr_clr_hen", 32'(hen), 32'd1);
        check("cr_clr_hl", 32'(hl), 32'd0);
        check("cr_clr_hx", 32'(hx), 32'd12);
        check("cr_clr_hy", 32'(hy), 32'd59);
        tick();
        check("cr_set_hl", 32'(hl), 32'd1);
        check("cr_set_hx", 32'(hx), 32'd0);
        check("cr_set_hy", 32'(hy), 32'd0);
        wait_idle();

        // Last cell of large grid wraps to (0,0)
        enter_n(59);
        type_n(79);
        key(7'h7A);
        check("wrapL_cx", 32'(cx), 32'd79);
        check("wrapL_cy", 32'(cy), 32'd59);
        check("wrapL_cascii", 32'(cascii), 32'h7A);
        tick();
        check("wrapL_clr_hx", 32'(hx), 32'd79);
        check("wrapL_clr_hy", 32'(hy), 32'd59);
        tick();
        check("wrapL_set_hx", 32'(hx), 32'd0);
        check("wrapL_set_hy", 32'(hy), 32'd0);
        wait_idle();
        check("wrapL_curx", 32'(curx), 32'd0);
        check("wrapL_cury", 32'(cury), 32'd0);

        // Mode switch homes the cursor
        enter_n(40);
        type_n(50);
        sL = 1'b0;
        tick();
        check("sl_clr_hen", 32'(hen), 32'd1);
        check("sl_clr_hl", 32'(hl), 32'd0);
        check("sl_clr_hx", 32'(hx), 32'd50);
        check("sl_clr_hy", 32'(hy), 32'd40);
        tick();
        check("sl_set_hl", 32'(hl), 32'd1);
        check("sl_set_hx", 32'(hx), 32'd0);
        check("sl_set_hy", 32'(hy), 32'd0);
        wait_idle();
        check("sl_curx", 32'(curx), 32'd0);
        check("sl_cury", 32'(cury), 32'd0);

        // Last cell of small grid wraps to (0,0)
        enter_n(29);
        type_n(39);
        key(7'h7A);
        check("wrapS_cx", 32'(cx), 32'd39);
        check("wrapS_cy", 32'(cy), 32'd29);
        wait_idle();
        check("wrapS_curx", 32'(curx), 32'd0);
        check("wrapS_cury", 32'(cury), 32'd0);
        enter_n(30);
        check("crS_cury", 32'(cury), 32'd0);

        // Asynchronous reset during the highlight clear
        key(7'h51);
        tick();
        check("mid_hen", 32'(hen), 32'd1);
        resetn = 1'b0;
        #1;
        check("mid_rst_hen", 32'(hen), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_cx", 32'(cx), 32'd0);
        check("mid_rst_cascii", 32'(cascii), 32'd0);
        check("mid_rst_curx", 32'(curx), 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        check("reinit_hen", 32'(hen), 32'd1);
        check("reinit_hl", 32'(hl), 32'd1);
        check("reinit_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
